btn_debounce: RTL and testbench



---
 rtl/btn_debounce_pkg.sv | 24 ++
 rtl/btn_debounce_lane.sv | 74 +++++++
 rtl/btn_debounce.sv | 38 +++
 tb/tb_btn_debounce.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_pkg
// Description : Shared defaults and types for the button debouncer and the
//               LED/button controller that consumes its clean levels.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_debounce_pkg;

    localparam int BTN_WIDTH_DEF       = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_WIDTH_DEF       = 20;

    // Short qualification window so simulations finish in a few cycles.
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
    } btn_evt_t;

endpackage : btn_debounce_pkg
`default_nettype wire

// File: rtl/btn_debounce_lane.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_lane
// Description : Single-button 2-flop synchroniser, stability counter, clean
//               level and registered rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_lane
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    btn_evt_t             evt_q;
    btn_evt_t             evt_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synchronised input matches the clean level restarts
    // the count, so only an uninterrupted run can flip the level.
    always_comb begin
        cnt_d      = '0;
        evt_d      = evt_q;
        evt_d.rise = 1'b0;
        evt_d.fall = 1'b0;
        if (sync2_q != evt_q.clean) begin
            if (cnt_q == CNT_LAST) begin
                evt_d.clean = sync2_q;
                evt_d.rise  = sync2_q;
                evt_d.fall  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign clean_o = evt_q.clean;
    assign rise_o  = evt_q.rise;
    assign fall_o  = evt_q.fall;

endmodule : btn_debounce_lane
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Multi-lane push-button debouncer; one independent lane per
//               button feeding the controller's btn input.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int BTN_WIDTH       = BTN_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [BTN_WIDTH-1:0] btn_raw,
    output logic [BTN_WIDTH-1:0] btn_clean,
    output logic [BTN_WIDTH-1:0] btn_rise,
    output logic [BTN_WIDTH-1:0] btn_fall
);

    for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_lane
        btn_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_lane (
            .clk     (clk),
            .resetN  (resetN),
            .raw_i   (btn_raw[g]),
            .clean_o (btn_clean[g]),
            .rise_o  (btn_rise[g]),
            .fall_o  (btn_fall[g])
        );
    end

endmodule : btn_debounce
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce
// Description : Scoreboard bench for btn_debounce (window 4 and window 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;
    import btn_debounce_pkg::*;

    logic       clk;
    logic       resetN;
    logic [3:0] btn_raw;
    logic [3:0] btn_clean,  btn_rise,  btn_fall;
    logic [3:0] btn_clean1, btn_rise1, btn_fall1;

    btn_debounce #(
        .BTN_WIDTH       (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .CNT_WIDTH       (3)
    ) u_dut (
        .clk       (clk),
        .resetN    (resetN),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    btn_debounce #(
        .BTN_WIDTH       (4),
        .DEBOUNCE_CYCLES (1),
        .CNT_WIDTH       (1)
    ) u_dut_d1 (
        .clk       (clk),
        .resetN    (resetN),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean1),
        .btn_rise  (btn_rise1),
        .btn_fall  (btn_fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] clean1;
        logic [3:0] rise1;
        logic [3:0] fall1;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   rise_cnt [4];

    // Raw samples taken at each edge; index 0 is the newest.  The two-flop
    // synchroniser means the value seen by the counter at edge e is rawh[2].
    logic [3:0] rawh [0:5];
    logic [3:0] m_clean;
    logic [3:0] m_clean1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A lane's clean level flips when the last d synchronised samples all
    // disagree with it.
    function automatic logic [3:0] flips(input int d, input logic [3:0] cl);
        logic [3:0] f;
        f = 4'hF;
        for (int j = 0; j < d; j++) f &= rawh[j+2] ^ cl;
        return f;
    endfunction

    // Reference model: one expected entry per clock edge (zeros while reset).
    initial begin
        exp_t       e;
        logic [3:0] f;
        logic [3:0] f1;
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                for (int i = 0; i < 6; i++) rawh[i] = 4'h0;
                m_clean  = 4'h0;
                m_clean1 = 4'h0;
                sb_q.delete();
                e = '{default: 4'h0};
                sb_q.push_back(e);
            end else begin
                for (int i = 5; i > 0; i--) rawh[i] = rawh[i-1];
                rawh[0]  = btn_raw;
                f        = flips(DEBOUNCE_CYCLES_SIM, m_clean);
                f1       = flips(1, m_clean1);
                e.clean  = m_clean ^ f;
                e.rise   = f & e.clean;
                e.fall   = f & ~e.clean;
                e.clean1 = m_clean1 ^ f1;
                e.rise1  = f1 & e.clean1;
                e.fall1  = f1 & ~e.clean1;
                m_clean  = e.clean;
                m_clean1 = e.clean1;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: every cycle presents a result; compare on the falling edge.
    initial begin
        exp_t e;
        for (int i = 0; i < 4; i++) rise_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) rise_cnt[i] += int'(btn_rise[i]);
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("clean",  {28'd0, btn_clean},  {28'd0, e.clean});
                chk("rise",   {28'd0, btn_rise},   {28'd0, e.rise});
                chk("fall",   {28'd0, btn_fall},   {28'd0, e.fall});
                chk("clean1", {28'd0, btn_clean1}, {28'd0, e.clean1});
                chk("rise1",  {28'd0, btn_rise1},  {28'd0, e.rise1});
                chk("fall1",  {28'd0, btn_fall1},  {28'd0, e.fall1});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic async_reset(input int hold);
        resetN = 1'b0;
        #1;
        chk("async_rst_outputs", {20'd0, btn_clean, btn_rise, btn_fall}, 32'd0);
        step(hold);
        resetN = 1'b1;
    endtask

    initial begin
        int r0;
        resetN  = 1'b0;
        btn_raw = 4'hF;

        // Reset held with buttons pressed, then release and qualify.
        step(10);
        resetN = 1'b1;
        step(10);
        chk("release_clean", {28'd0, btn_clean}, 32'hF);
        btn_raw = 4'h0;
        step(10);

        // Clean press/release on lane 0.
        r0 = rise_cnt[0];
        btn_raw[0] = 1'b1;
        step(8);
        btn_raw[0] = 1'b0;
        step(8);
        chk("press_rise_count", 32'(rise_cnt[0] - r0), 32'd1);

        // Bounce on lane 1 then hold.
        r0 = rise_cnt[1];
        btn_raw[1] = 1'b1; step(1);
        btn_raw[1] = 1'b0; step(1);
        btn_raw[1] = 1'b1; step(1);
        btn_raw[1] = 1'b0; step(1);
        btn_raw[1] = 1'b1; step(12);
        chk("bounce_rise_count", 32'(rise_cnt[1] - r0), 32'd1);
        btn_raw[1] = 1'b0;
        step(8);

        // Short glitch on lane 2 must not qualify.
        r0 = rise_cnt[2];
        btn_raw[2] = 1'b1; step(3);
        btn_raw[2] = 1'b0; step(10);
        chk("glitch_rise_count", 32'(rise_cnt[2] - r0), 32'd0);
        chk("glitch_clean", {31'd0, btn_clean[2]}, 32'd0);

        // Reset mid-count on lane 3, then re-qualify from scratch.
        btn_raw[3] = 1'b1;
        step(2);
        async_reset(2);
        step(10);
        chk("requal_clean", {31'd0, btn_clean[3]}, 32'd1);
        btn_raw = 4'h0;
        step(10);

        // Staggered presses across lanes.
        btn_raw = 4'b0101; step(2);
        btn_raw = 4'b1111; step(10);
        btn_raw = 4'h0;    step(10);

        // Randomised bouncing with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
            if ($urandom_range(0, 399) == 0) async_reset($urandom_range(1, 3));
            else step(1);
        end
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_btn_debounce
`default_nettype wire
